// File: rtl/field_packer.sv
// Purpose: packs six 5-bit fields plus a 2-bit trailer into a 32-bit frame, emitted as 4 bytes MSB-first.
// Latency: byte 0 valid the cycle after field 5 is accepted; 10 cycles per frame with no stalls.
// Backpressure: out_ready=0 holds the current byte stable; in_ready is low for the whole emit phase.
module field_packer #(
    parameter logic [1:0] TRAILER = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [4:0] in_field,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] frame_q, frame_d;
    logic [2:0]  fidx_q, fidx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic field_acc;
    logic byte_xfer;

    assign field_acc = (state_q == COLLECT) && in_valid;
    assign byte_xfer = (state_q == EMIT) && out_ready;

    // Next-state logic: clr overrides any accept or transfer in the same cycle.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        fidx_d      = fidx_q;
        bidx_d      = bidx_q;
        frame_cnt_d = frame_cnt_q;
        if (clr) begin
            state_d = COLLECT;
            frame_d = 32'h0;
            fidx_d  = 3'd0;
            bidx_d  = 2'd0;
        end else if (field_acc) begin
            case (fidx_q)
                3'd0:    frame_d[31:27] = in_field;
                3'd1:    frame_d[26:22] = in_field;
                3'd2:    frame_d[21:17] = in_field;
                3'd3:    frame_d[16:12] = in_field;
                3'd4:    frame_d[11:7]  = in_field;
                default: frame_d[6:2]   = in_field;
            endcase
            if (fidx_q == 3'd5) begin
                frame_d[1:0] = TRAILER;
                state_d      = EMIT;
                fidx_d       = 3'd0;
                bidx_d       = 2'd0;
            end else begin
                fidx_d = fidx_q + 3'd1;
            end
        end else if (byte_xfer) begin
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
                state_d     = COLLECT;
                frame_d     = 32'h0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            frame_q     <= 32'h0;
            fidx_q      <= 3'd0;
            bidx_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            fidx_q      <= fidx_d;
            bidx_q      <= bidx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Output decode: byte select by byte index, zero outside the emit phase.
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == EMIT);
        out_last  = (state_q == EMIT) && (bidx_q == 2'd3);
        out_byte  = 8'h00;
        if (state_q == EMIT) begin
            case (bidx_q)
                2'd0:    out_byte = frame_q[31:24];
                2'd1:    out_byte = frame_q[23:16];
                2'd2:    out_byte = frame_q[15:8];
                default: out_byte = frame_q[7:0];
            endcase
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule
